// File: rtl/bscalc_fixed_pkg.sv
// Shared Q16.16 fixed-point constants and FSM state encoding for the
// exponential and logarithm calculator blocks.
package bscalc_fixed_pkg;

  localparam int FRAC_BITS = 16;

  // ln(2) and 1/ln(2) in Q16.16
  localparam logic signed [31:0] LN2     = 32'sh0000B172;
  localparam logic signed [31:0] INV_LN2 = 32'sh00017154;

  // Taylor coefficients of exp(r): 1, 1, 1/2, 1/6, 1/24 in Q16.16
  localparam logic signed [31:0] C0 = 32'sh00010000;
  localparam logic signed [31:0] C1 = 32'sh00010000;
  localparam logic signed [31:0] C2 = 32'sh00008000;
  localparam logic signed [31:0] C3 = 32'sh00002AAB;
  localparam logic signed [31:0] C4 = 32'sh00000AAB;

  // Calculator sequencing states; encodings 5..7 are unused
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    POLY   = 3'd2,
    SCALE  = 3'd3,
    HOLD   = 3'd4
  } state_t;

endpackage

// File: rtl/q16_mul.sv
// Combinational signed Q16.16 multiply: full-width product, arithmetic
// shift right by the fraction width, truncated back to WIDTH.
module q16_mul
  import bscalc_fixed_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0] full_prod;

  // Sign-extend both operands so the product is exact before rescaling
  always_comb begin
    full_prod = PW'(a) * PW'(b);
    p         = WIDTH'(full_prod >>> FRAC_BITS);
  end

endmodule

// File: rtl/exponential.sv
// exp(x) for signed Q16.16 arguments. x is range-reduced to x = k*ln2 + r
// with 0 <= r < ln2, exp(r) is evaluated with a degree-4 Horner polynomial,
// and the result is scaled by 2^k with saturation/underflow handling.
// start and in are registered on entry; the FSM acts on the registered copy,
// which places the result four edges after the start edge and allows a new
// start on the edge that ends HOLD.
module exponential
  import bscalc_fixed_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] in,
  output logic signed [WIDTH-1:0] out,
  output logic                    valid,
  output logic                    busy
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};

  state_t                  state_q, state_d;
  logic                    start_q, start_d;
  logic signed [WIDTH-1:0] in_q, in_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [WIDTH-1:0] k_q, k_d;
  logic signed [WIDTH-1:0] r_q, r_d;
  logic signed [WIDTH-1:0] p_q, p_d;
  logic signed [WIDTH-1:0] out_q, out_d;
  logic                    valid_q, valid_d;

  logic signed [PW-1:0]    x_wide, kx_prod, k_wide, r_wide;
  logic signed [WIDTH-1:0] k_red, r_red;
  logic signed [WIDTH-1:0] horner_acc [0:4];
  logic signed [WIDTH-1:0] horner_prod [0:3];
  logic signed [WIDTH-1:0] scaled;

  // Range reduction: k = floor(x/ln2) from the full product, then one
  // correction step pulls r back into [0, ln2)
  always_comb begin
    x_wide  = PW'(x_q);
    kx_prod = x_wide * PW'(INV_LN2);
    k_wide  = kx_prod >>> (2 * FRAC_BITS);
    r_wide  = x_wide - k_wide * PW'(LN2);
    if (r_wide < 0) begin
      k_wide = k_wide - 1;
      r_wide = r_wide + PW'(LN2);
    end else if (r_wide >= PW'(LN2)) begin
      k_wide = k_wide + 1;
      r_wide = r_wide - PW'(LN2);
    end
    k_red = WIDTH'(k_wide);
    r_red = WIDTH'(r_wide);
  end

  // All four Horner products must settle within the single POLY cycle,
  // so each stage has its own multiplier rather than sharing one
  assign horner_acc[0] = WIDTH'(C4);

  for (genvar gi = 0; gi < 4; gi++) begin : g_horner
    localparam logic signed [WIDTH-1:0] COEF =
      (gi == 0) ? WIDTH'(C3) :
      (gi == 1) ? WIDTH'(C2) :
      (gi == 2) ? WIDTH'(C1) : WIDTH'(C0);

    q16_mul #(.WIDTH(WIDTH)) u_mul (
      .a (horner_acc[gi]),
      .b (r_q),
      .p (horner_prod[gi])
    );

    assign horner_acc[gi+1] = horner_prod[gi] + COEF;
  end

  // Scale p by 2^k: saturate when k is too large, flush to zero when too small
  always_comb begin
    if (k_q >= 15) begin
      scaled = SAT_POS;
    end else if (k_q >= 0) begin
      scaled = p_q << k_q[3:0];
    end else if (k_q >= -31) begin
      scaled = p_q >>> 5'(-k_q);
    end else begin
      scaled = '0;
    end
  end

  // Next-state and register updates; everything holds unless its state writes it
  always_comb begin
    state_d = state_q;
    start_d = start;
    in_d    = in;
    x_d     = x_q;
    k_d     = k_q;
    r_d     = r_q;
    p_d     = p_q;
    out_d   = out_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start_q) begin
          x_d     = in_q;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        k_d     = k_red;
        r_d     = r_red;
        state_d = POLY;
      end
      POLY: begin
        p_d     = horner_acc[4];
        state_d = SCALE;
      end
      SCALE: begin
        out_d   = scaled;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      in_q    <= '0;
      x_q     <= '0;
      k_q     <= '0;
      r_q     <= '0;
      p_q     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      in_q    <= in_d;
      x_q     <= x_d;
      k_q     <= k_d;
      r_q     <= r_d;
      p_q     <= p_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = (state_q != IDLE);

endmodule
